// File: rtl/arb_pkg.sv
// Shared definitions for the two-requester output-channel arbiter.
// State encoding and the default burst limit live here so callers agree on them.
package arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SERVE0 = 2'd1,
        ST_SERVE1 = 2'd2
    } state_t;

    localparam int DEF_MAX_BURST = 4;

endpackage

// File: rtl/mux4_2_1.sv
// 4-bit 2:1 data multiplexer; s=1 selects in1.
module mux4_2_1 (
    input  logic [3:0] in0,
    input  logic [3:0] in1,
    input  logic       s,
    output logic [3:0] y
);

    assign y = s ? in1 : in0;

endmodule

// File: rtl/mux2_arbiter.sv
// Round-robin arbiter sharing one 4-bit registered output channel between two
// requesters, with a burst limit so a busy requester cannot starve the other.
module mux2_arbiter
    import arb_pkg::*;
#(
    parameter int MAX_BURST = DEF_MAX_BURST,
    parameter int CNT_W     = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] in_valid,
    input  logic [3:0] in_data0,
    input  logic [3:0] in_data1,
    output logic [1:0] in_ready,
    output logic       out_valid,
    output logic [3:0] out_data,
    output logic       out_src,
    input  logic       out_ready,
    output logic [1:0] grant
);

    state_t           state;
    logic             last;
    logic [CNT_W-1:0] burst_cnt;
    logic [3:0]       mux_y;

    logic serving;
    logic cur;
    logic oth;
    logic can_load;
    logic xfer;
    logic burst_end;

    function automatic state_t serve_state(input logic r);
        return r ? ST_SERVE1 : ST_SERVE0;
    endfunction

    function automatic logic [1:0] serve_grant(input logic r);
        return r ? 2'b10 : 2'b01;
    endfunction

    mux4_2_1 u_mux (
        .in0 (in_data0),
        .in1 (in_data1),
        .s   (grant[1]),
        .y   (mux_y)
    );

    // Accept only when the output slot is free or being drained this cycle.
    always_comb begin
        serving   = (state == ST_SERVE0) || (state == ST_SERVE1);
        cur       = (state == ST_SERVE1);
        oth       = ~cur;
        can_load  = ~out_valid | out_ready;
        in_ready  = 2'b00;
        if (!rst && serving && can_load)
            in_ready = serve_grant(cur);
        xfer      = |(in_valid & in_ready);
        burst_end = (burst_cnt == CNT_W'(MAX_BURST - 1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            grant     <= 2'b00;
            last      <= 1'b1;
            burst_cnt <= '0;
            out_valid <= 1'b0;
            out_data  <= 4'd0;
            out_src   <= 1'b0;
        end else begin
            if (xfer) begin
                out_data  <= mux_y;
                out_src   <= cur;
                out_valid <= 1'b1;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end

            case (state)
                ST_SERVE0, ST_SERVE1: begin
                    // A stalled output freezes ownership and the burst count.
                    if (can_load) begin
                        if (!in_valid[cur]) begin
                            last      <= cur;
                            burst_cnt <= '0;
                            if (in_valid[oth]) begin
                                state <= serve_state(oth);
                                grant <= serve_grant(oth);
                            end else begin
                                state <= ST_IDLE;
                                grant <= 2'b00;
                            end
                        end else if (burst_end) begin
                            burst_cnt <= '0;
                            if (in_valid[oth]) begin
                                last  <= cur;
                                state <= serve_state(oth);
                                grant <= serve_grant(oth);
                            end
                        end else begin
                            burst_cnt <= burst_cnt + CNT_W'(1);
                        end
                    end
                end
                default: begin
                    burst_cnt <= '0;
                    if (in_valid[0] && (!in_valid[1] || last)) begin
                        state <= ST_SERVE0;
                        grant <= 2'b01;
                    end else if (in_valid[1]) begin
                        state <= ST_SERVE1;
                        grant <= 2'b10;
                    end else begin
                        state <= ST_IDLE;
                        grant <= 2'b00;
                    end
                end
            endcase
        end
    end

endmodule

// File: doc/mux2_arbiter.md
Name: mux2_arbiter

Overview:
- Round-robin arbiter and sequencer sharing one 4-bit output channel between two requesters.
- Drives the select of the team's 4-bit 2:1 mux (mux4_2_1) from its grant state.
- Registers the selected beat into a single-entry output stage with a valid/ready handshake.
- Enforces a maximum burst length so neither requester can starve the other.

Parameters:
- MAX_BURST, 4: maximum consecutive beats granted to one requester while the other is requesting (legal range 1..15).
- CNT_W, 4: width of the burst counter; must hold MAX_BURST-1.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset.
- in_valid  input  2  bit i = requester i has a beat.
- in_data0  input  4  requester 0 data.
- in_data1  input  4  requester 1 data.
- in_ready  output  2  bit i = requester i beat accepted this cycle if in_valid[i].
- out_valid  output  1  output register holds a beat.
- out_data  output  4  registered beat.
- out_src  output  1  requester that supplied out_data.
- out_ready  input  1  consumer accepts out_data this cycle.
- grant  output  2  one-hot current owner; 00 when idle.

Behaviour:
- Clocking and reset: one clock (clk); reset (rst) is synchronous and active-high.
- Reset values: state=IDLE, grant=00, in_ready=00, out_valid=0, out_data=0, out_src=0, burst_cnt=0, last=1 (requester 0 wins the first tie).
- in_ready is forced to 00 while rst=1.
- States:
  - IDLE: grant=00.
  - SERVE0: grant=01.
  - SERVE1: grant=10.
- IDLE transitions (next cycle):
  - No in_valid: stay.
  - One in_valid: go to SERVE of that requester.
  - Both: go to SERVE of requester !last.
  - No beat is accepted in IDLE, giving a 1-cycle arbitration bubble.
- in_ready[g] = (state==SERVEg) & (!out_valid | out_ready). The non-granted bit is always 0.
- Mux select s = (state==SERVE1).
- Transfer on requester g = in_valid[g] & in_ready[g]. At the next edge:
  - out_data <= mux output;
  - out_src <= g;
  - out_valid <= 1.
  - Input-to-output latency is 1 cycle.
- Drain: out_valid & out_ready with no transfer clears out_valid at the next edge. A simultaneous drain and load keeps out_valid=1 with the new beat, so throughput is 1 beat/cycle.
- Burst counter:
  - Increments on each transfer in a SERVE state.
  - Resets to 0 on any state change.
- Leaving SERVEg (g = owner, o = other):
  - Release: in_valid[g]=0 in a cycle. Next state is SERVEo if in_valid[o], else IDLE. last <= g.
  - Forced switch: transfer with burst_cnt==MAX_BURST-1 and in_valid[o]=1. Next state is SERVEo with no bubble. last <= g.
  - Transfer with burst_cnt==MAX_BURST-1 and in_valid[o]=0: stay in SERVEg, burst_cnt <= 0.
  - Otherwise stay in SERVEg.
- Backpressure: out_valid=1 and out_ready=0 hold all state and the burst counter. in_ready=00 during that time.
- Requester rule: in_valid and data must stay stable until accepted. Dropping valid before acceptance is treated as release, and the arbiter must not accept that beat.
- Reset mid-operation: the output beat is discarded, a pending grant is lost, and all values return to their reset values at the edge.
- out_valid, out_data, out_src and grant are all registered; no combinational path runs from out_ready to them.

Decomposition:
- Shared package arb_pkg holds:
  - state encoding constants ST_IDLE=2'd0, ST_SERVE0=2'd1, ST_SERVE1=2'd2;
  - the default MAX_BURST constant.
- One sub-module instance: mux4_2_1 for the data select (in0=in_data0, in1=in_data1, s=grant[1]).
- FSM, burst counter and output register are implemented in this module.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, no requests -> grant=00, in_ready=00, out_valid=0, out_data=0 throughout.
- Single requester: in_valid=01 with data 0x3 then 0x5, out_ready=1 -> grant=01 one cycle after the request. Beats are accepted on consecutive cycles, with out_data=0x3 then 0x5 one cycle after each acceptance and out_src=0.
- Tie from IDLE: in_valid=11 after reset -> SERVE0 first. Requester 0 then drops valid -> SERVE1, and requester 1's data 0xA appears with out_src=1.
- Burst limit: both requesting continuously, out_ready=1, MAX_BURST=4 -> four beats from requester 0, then four from requester 1, alternating with no bubble at the switches.
- Backpressure: out_valid=1, out_ready=0 for 3 cycles -> in_ready=00, out_data unchanged, burst_cnt frozen. out_ready=1 resumes 1 beat/cycle.
- Reset mid-burst: rst=1 during SERVE1 with out_valid=1 -> next cycle out_valid=0, grant=00, last=1. After a new tie, requester 0 is granted first.
